// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sa_state_t;

    localparam int SA_WIDTH_DEF = 16;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fullAdder_1b.sv
// One-bit full adder shared by the serial datapath.
module fullAdder_1b (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_FLAGS_EN to build the ovf and zero flag logic.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;

    fullAdder_1b u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

`ifdef SERIAL_ADDER_FLAGS_EN
    logic ovf_c;
    logic zacc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
            ovf_c <= 1'b0;
            zacc  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        res   <= '0;
`ifdef SERIAL_ADDER_FLAGS_EN
                        zacc  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    res   <= {fa_s, res[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
`ifdef SERIAL_ADDER_FLAGS_EN
                    zacc  <= zacc | fa_s;
                    // carry-in of the MSB, xor'd with carry-out for ovf
                    if (cnt == LAST) ovf_c <= carry;
`endif
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = out_valid ? res : '0;
    assign cout      = out_valid & carry;

`ifdef SERIAL_ADDER_FLAGS_EN
    assign ovf  = out_valid & (ovf_c ^ carry);
    assign zero = out_valid & ~zacc;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, random ops, stalls, reset.
module tb_serial_adder;

    localparam int W = 16;
`ifdef SERIAL_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference from integer arithmetic, not from the bit-serial recurrence
    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        vec_t v;
        int   ux, uy, sx, sy, ur, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        v.a = x;
        v.b = y;
        v.sub = s;
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            v.cout = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            v.cout = (ur > 65535);
        end
        v.sum  = ur[W-1:0];
        v.ovf  = (sr > 32767) || (sr < -32768);
        v.zero = (v.sum == '0);
        return v;
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s);
        a = x;
        b = y;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            if (out_valid) begin
                lat = n - 1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_result(input string tag, input vec_t e);
        chk({tag, " sum"}, 32'(sum), 32'(e.sum));
        chk({tag, " cout"}, 32'(cout), 32'(e.cout));
        chk({tag, " ovf"}, 32'(ovf), 32'(e.ovf & FLAGS));
        chk({tag, " zero"}, 32'(zero), 32'(e.zero & FLAGS));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after consume"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t e, input bit chk_lat);
        int lat;
        start_op(e.a, e.b, e.sub);
        chk({tag, " in_ready in RUN"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        if (chk_lat) chk({tag, " latency"}, 32'(lat), 32'd16);
        else if (lat < 0) chk({tag, " timeout"}, 32'd1, 32'd0);
        check_result(tag, e);
        consume(tag);
    endtask

    vec_t tbl[7];
    vec_t e;
    vec_t e2;
    logic [W-1:0] held;
    int lat;

    initial begin
        tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], 1'b1);

        for (int i = 0; i < 30; i++) begin
            e = model(W'($urandom), W'($urandom), 1'($urandom));
            if (i % 5 == 0) e = model(e.a, e.a, e.sub);
            run_vec($sformatf("rnd%0d", i), e, 1'b0);
        end

        // stall in DONE with an ignored input pulse
        e = model(16'h4321, 16'h1234, 1'b0);
        start_op(e.a, e.b, e.sub);
        wait_done(lat);
        chk("bp latency", 32'(lat), 32'd16);
        held = sum;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                a = 16'h1111;
                b = 16'h2222;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp sum held", 32'(sum), 32'(held));
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        check_result("bp", e);
        consume("bp");
        e2 = model(16'h0F0F, 16'h00F1, 1'b1);
        run_vec("after bp", e2, 1'b1);

        // reset in the middle of a run
        start_op(16'h1234, 16'h1111, 1'b0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid-reset out_valid", 32'(out_valid), 32'd0);
        chk("mid-reset sum", 32'(sum), 32'd0);
        chk("mid-reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = model(16'h0001, 16'h0002, 1'b0);
        chk("post-reset model", 32'(e.sum), 32'h0003);
        run_vec("post-reset", e, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
